// File: rtl/simple_in_and_out.sv
// Edge-of-design status block: synchronises three raw inputs and registers
// their AND / OR, with a valid flag once the pipeline holds post-reset data.
module simple_in_and_out #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic in_1,
  input  logic in_2,
  input  logic in_3,
  output logic out_1,
  output logic out_2,
  output logic out_valid
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [2:0]                  in_vec;
  logic [2:0]                  sync_tail;
  logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        out1_q, out1_d;
  logic                        out2_q, out2_d;
  logic                        valid_q, valid_d;

  assign in_vec = {in_3, in_2, in_1};

  // Synchroniser chains shift every cycle; enable only gates the output register.
  always_comb begin
    sync_d    = sync_q;
    sync_tail = '0;
    for (int i = 0; i < 3; i++) begin
      sync_d[i][0] = in_vec[i];
      for (int j = 1; j < int'(SYNC_STAGES); j++) begin
        sync_d[i][j] = sync_q[i][j-1];
      end
      sync_tail[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    out1_d  = out1_q;
    out2_d  = out2_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (enable) begin
      out1_d = &sync_tail;
      out2_d = |sync_tail;
    end
    // Fill counter saturates once the whole pipeline has been refreshed.
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    valid_d = valid_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      out1_q  <= 1'b0;
      out2_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      valid_q <= valid_d;
    end
  end

  assign out_1     = out1_q;
  assign out_2     = out2_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_simple_in_and_out.sv
// Directed bench for simple_in_and_out at SYNC_STAGES = 1, 2, 4, checked
// against an edge-history model plus literal expectations.
module tb_simple_in_and_out;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic in_1 = 1'b1, in_2 = 1'b1, in_3 = 1'b1;
  logic [2:0] out1_w, out2_w, val_w;

  int errors = 0;
  int checks = 0;

  localparam int NI = 3;
  int stages [NI] = '{1, 2, 4};

  always #5 clk = ~clk;

  simple_in_and_out #(.SYNC_STAGES(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out_1(out1_w[0]), .out_2(out2_w[0]), .out_valid(val_w[0]));
  simple_in_and_out #(.SYNC_STAGES(2)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out_1(out1_w[1]), .out_2(out2_w[1]), .out_valid(val_w[1]));
  simple_in_and_out #(.SYNC_STAGES(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out_1(out1_w[2]), .out_2(out2_w[2]), .out_valid(val_w[2]));

  // Model: history of inputs/enable seen at each edge since the last reset release.
  localparam int HN = 2048;
  logic [2:0] smp  [HN];
  logic       en_h [HN];
  int         n = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n <= 0;
    end else if (n < HN - 1) begin
      smp[n+1]  <= {in_1, in_2, in_3};
      en_h[n+1] <= enable;
      n         <= n + 1;
    end
  end

  // Returns {valid, out_2, out_1} expected after edge `e` for a given stage count.
  function automatic logic [2:0] model(int s, int e);
    int m;
    logic [2:0] v;
    m = e;
    while (m >= 1 && !en_h[m]) m--;
    v = 3'b000;
    if (m >= 1 && (m - s) >= 1) v = smp[m-s];
    return {(e >= s + 1) ? 1'b1 : 1'b0, |v, &v};
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("model_s%0d", stages[i]), {val_w[i], out2_w[i], out1_w[i]},
          model(stages[i], n));
    end
  end

  task automatic set_in(input logic [2:0] v);
    {in_1, in_2, in_3} = v;
  endtask

  logic [2:0] sweep_in  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [1:0] sweep_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with inputs 111: everything stays at zero.
    repeat (4) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_hold_s%0d", stages[i]), {val_w[i], out2_w[i], out1_w[i]}, 3'b000);

    // Release; out_valid of the SYNC_STAGES=2 instance rises on the third edge.
    reset = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk($sformatf("valid_fill_e%0d", j), {2'b00, val_w[1]}, (j >= 3) ? 3'b001 : 3'b000);
    end

    // Truth sweep, 50 cycles per vector, sampled at the end of each hold.
    foreach (sweep_in[k]) begin
      set_in(sweep_in[k]);
      repeat (50) @(negedge clk);
      for (int i = 0; i < NI; i++)
        chk($sformatf("truth_%b_s%0d", sweep_in[k], stages[i]),
            {1'b0, out2_w[i], out1_w[i]}, {1'b0, sweep_exp[k]});
    end

    // Latency: step 000 -> 111 just before edge k; out_1 rises on edge k+S.
    set_in(3'b000);
    repeat (10) @(negedge clk);
    set_in(3'b111);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        chk($sformatf("latency_s%0d_e%0d", stages[i], j), {2'b00, out1_w[i]},
            (j >= stages[i] + 1) ? 3'b001 : 3'b000);
    end

    // Enable hold: outputs frozen at (0,1) while inputs go to 111.
    set_in(3'b001);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    set_in(3'b111);
    repeat (10) begin
      @(negedge clk);
      chk("enable_hold", {1'b0, out2_w[1], out1_w[1]}, 3'b010);
    end
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("enable_resume_s%0d", stages[i]), {1'b0, out2_w[i], out1_w[i]}, 3'b011);

    // Mid-operation reset: 3 ns pulse between edges clears outputs at once.
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("async_reset_s%0d", stages[i]), {val_w[i], out2_w[i], out1_w[i]}, 3'b000);
    #2 reset = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("refill_valid_e%0d", j), {2'b00, val_w[1]}, (j >= 3) ? 3'b001 : 3'b000);
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("recovered_s%0d", stages[i]), {val_w[i], out2_w[i], out1_w[i]}, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simple_in_and_out.md
Name: simple_in_and_out

Overview:
Small registered logic block that reduces three single-bit control inputs to two status flags.
- out_1 is the AND of all three inputs.
- out_2 is the OR of all three inputs.

Inputs are synchronised into the clk domain before evaluation, so asynchronous or board-level signals can drive them directly. The block sits at the edge of the design, between raw inputs and downstream control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input; legal range 1..4.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  output-register update enable; synchronous to clk.
- in_1  input  1  data input 1; may be asynchronous to clk.
- in_2  input  1  data input 2; may be asynchronous to clk.
- in_3  input  1  data input 3; may be asynchronous to clk.
- out_1  output  1  registered in_1 AND in_2 AND in_3.
- out_2  output  1  registered in_1 OR in_2 OR in_3.
- out_valid  output  1  high once the pipeline holds post-reset data.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset=1: all synchroniser flops, out_1, out_2, out_valid and the fill counter are forced to 0 immediately, independent of clk.
  - Release takes effect on the first rising clk edge with reset=0.
- Synchroniser: each in_x passes through a chain of SYNC_STAGES flops clocked every cycle.
  - The chain shifts regardless of enable.
  - sN_x denotes the last stage of the chain for in_x.
- Output register: on a rising edge with enable=1:
  - out_1 <= s_1 & s_2 & s_3
  - out_2 <= s_1 | s_2 | s_3
- enable=0: out_1 and out_2 hold their previous values.
- Latency: an input change that is stable before edge k appears on the outputs after edge k+SYNC_STAGES, given enable=1 throughout. That is SYNC_STAGES+1 rising edges total.
- Fill counter and out_valid:
  - A counter of width ceil(log2(SYNC_STAGES+2)) increments on every rising edge after reset.
  - It saturates at SYNC_STAGES+1.
  - out_valid=1 once it saturates, and stays 1 until the next reset.
  - The counter advances independently of enable.
  - Downstream logic ignores out_1/out_2 while out_valid=0.
- Truth table after latency (in_1 in_2 in_3 -> out_1 out_2):
  - 000 -> 0 0
  - 001 -> 0 1
  - 010 -> 0 1
  - 011 -> 0 1
  - 100 -> 0 1
  - 101 -> 0 1
  - 110 -> 0 1
  - 111 -> 1 1
- Simultaneous input changes on several inputs are each sampled independently. A transient mixed value may appear for one cycle if the inputs straddle a clock edge; this is acceptable.
- Reset asserted mid-operation:
  - Outputs drop to 0 immediately.
  - The pipeline refills from scratch after release.
  - out_valid re-asserts after SYNC_STAGES+1 edges.
- No combinational path from any input to any output; all outputs are driven directly from flops.

Test Plan:
- Reset: hold reset=1 with inputs=111 -> out_1=0, out_2=0, out_valid=0. Release reset -> out_valid=1 exactly SYNC_STAGES+1 edges later (3 edges with the default).
- Truth sweep, enable=1: apply 000, 001, 010, 011, holding each for 50 cycles. Sample at the end of each hold -> (out_1, out_2) = (0,0), (0,1), (0,1), (0,1). Then apply 111 -> (1,1).
- Latency: step inputs 000->111 just before edge k -> out_1 rises on edge k+SYNC_STAGES, not earlier. Repeat with SYNC_STAGES=1 and 4.
- Enable hold: with outputs at (0,1), drop enable and apply 111 for 10 cycles -> outputs stay (0,1). Raise enable -> (1,1) on the next edge.
- Mid-operation reset: with outputs (1,1), pulse reset for 3 ns between clock edges -> outputs go to 0 during the pulse without a clock edge. Recovery: out_valid returns after SYNC_STAGES+1 edges and the outputs return to (1,1).
